// File: rtl/ppu_pkg.sv
// ppu_pkg: shared arbiter state/tag types and the read-tag pipe entry layout
package ppu_pkg;
    localparam int VRAM_ADDR_W = 13;
    typedef enum logic [1:0] {IDLE, BG_OWN, SPR_OWN} arb_state_t;
    typedef enum logic [1:0] {TAG_BG, TAG_SPR, TAG_CPU} req_tag_t;
    typedef struct packed {
        logic     valid;
        req_tag_t tag;
        logic     in_range;
    } pipe_ent_t;
endpackage

// File: rtl/ppu_read_tag_pipe.sv
// ppu_read_tag_pipe: DEPTH-stage shift register of {valid, tag, in_range} tracking reads in flight
//  clk_in, rst_n_in : clock, asynchronous active-low reset (clears every stage)
//  push_in          : entry captured this cycle (valid=0 when nothing granted)
//  head_out         : oldest stage, lines up with BRAM read data
//  bg_busy_out      : some stage holds a BG read
//  busy_out         : some stage holds any read
module ppu_read_tag_pipe
    import ppu_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic      clk_in,
    input  logic      rst_n_in,
    input  pipe_ent_t push_in,
    output pipe_ent_t head_out,
    output logic      bg_busy_out,
    output logic      busy_out
);
    pipe_ent_t q [DEPTH];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            q[0] <= push_in;
            for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
        end
    end

    always_comb begin
        bg_busy_out = 1'b0;
        busy_out    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bg_busy_out = bg_busy_out | (q[i].valid && q[i].tag == TAG_BG);
            busy_out    = busy_out | q[i].valid;
        end
        head_out = q[DEPTH-1];
    end
endmodule

// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter: shares the VRAM BRAM read port between BG and sprite fetchers (optional CPU via PPU_CPU_PORT_EN)
//  clk_in, rst_n_in           : clock, asynchronous active-low reset
//  bg_addr/valid_in, bg_grant_out, bg_data/data_valid_out     : background fetcher port
//  spr_addr/valid/active_in, spr_grant_out, spr_data/data_valid_out : sprite fetcher port
//  mem_free_out               : no BG read in flight and no BG grant this cycle
//  bram_addr_out, bram_data_in: VRAM BRAM read port (address registered on grant)
//  cpu_* ports                : present only when PPU_CPU_PORT_EN is defined
module ppu_vram_arbiter
    import ppu_pkg::*;
#(
    parameter int          READ_LATENCY = 2,
    parameter logic [15:0] VRAM_BASE    = 16'h8000,
    parameter int          VRAM_SIZE    = 8192
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [15:0]            bg_addr_in,
    input  logic                   bg_valid_in,
    output logic                   bg_grant_out,
    output logic [7:0]             bg_data_out,
    output logic                   bg_data_valid_out,
    input  logic [15:0]            spr_addr_in,
    input  logic                   spr_valid_in,
    input  logic                   spr_active_in,
    output logic                   spr_grant_out,
    output logic [7:0]             spr_data_out,
    output logic                   spr_data_valid_out,
`ifdef PPU_CPU_PORT_EN
    input  logic [15:0]            cpu_addr_in,
    input  logic                   cpu_valid_in,
    output logic                   cpu_grant_out,
    output logic [7:0]             cpu_data_out,
    output logic                   cpu_data_valid_out,
`endif
    output logic                   mem_free_out,
    output logic [VRAM_ADDR_W-1:0] bram_addr_out,
    input  logic [7:0]             bram_data_in
);
    arb_state_t  state, state_nxt;
    logic        cpu_req, cpu_gnt, gnt, in_range, bg_busy, busy;
    logic [15:0] cpu_addr, req_addr;
    logic [16:0] diff;
    logic [7:0]  rd_data;
    req_tag_t    req_tag;
    pipe_ent_t   head;

`ifdef PPU_CPU_PORT_EN
    assign cpu_req  = cpu_valid_in;
    assign cpu_addr = cpu_addr_in;
`else
    assign cpu_req  = 1'b0;
    assign cpu_addr = '0;
`endif

    // Pipe depth READ_LATENCY+1: one cycle for the address register, then BRAM latency
    ppu_read_tag_pipe #(.DEPTH(READ_LATENCY + 1)) u_pipe (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .push_in     ('{valid: gnt, tag: req_tag, in_range: in_range}),
        .head_out    (head),
        .bg_busy_out (bg_busy),
        .busy_out    (busy)
    );

    always_comb begin
        bg_grant_out  = bg_valid_in && !spr_active_in && (state == IDLE || state == BG_OWN);
        spr_grant_out = spr_valid_in && state == SPR_OWN;
        cpu_gnt       = cpu_req && state == IDLE && !bg_valid_in && !spr_active_in;
        gnt           = bg_grant_out || spr_grant_out || cpu_gnt;
        mem_free_out  = !bg_busy && !bg_grant_out;
        req_addr      = spr_grant_out ? spr_addr_in : bg_grant_out ? bg_addr_in : cpu_addr;
        req_tag       = spr_grant_out ? TAG_SPR : bg_grant_out ? TAG_BG : TAG_CPU;
        // 17-bit difference: bit 16 set means below VRAM_BASE
        diff          = {1'b0, req_addr} - {1'b0, VRAM_BASE};
        in_range      = !diff[16] && diff < 17'(VRAM_SIZE);
        state_nxt     = state;
        case (state)
            IDLE:    state_nxt = (spr_active_in && mem_free_out) ? SPR_OWN : bg_grant_out ? BG_OWN : IDLE;
            BG_OWN:  state_nxt = spr_active_in ? (bg_busy ? BG_OWN : SPR_OWN)
                               : (!bg_valid_in && !busy) ? IDLE : BG_OWN;
            SPR_OWN: state_nxt = (!spr_active_in && !busy) ? IDLE : SPR_OWN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            bram_addr_out <= '0;
        end else begin
            state <= state_nxt;
            if (gnt && in_range) bram_addr_out <= diff[VRAM_ADDR_W-1:0];
        end
    end

    always_comb begin
        rd_data            = head.in_range ? bram_data_in : 8'hFF;
        bg_data_valid_out  = head.valid && head.tag == TAG_BG;
        spr_data_valid_out = head.valid && head.tag == TAG_SPR;
        bg_data_out        = bg_data_valid_out ? rd_data : 8'h00;
        spr_data_out       = spr_data_valid_out ? rd_data : 8'h00;
`ifdef PPU_CPU_PORT_EN
        cpu_grant_out      = cpu_gnt;
        cpu_data_valid_out = head.valid && head.tag == TAG_CPU;
        cpu_data_out       = cpu_data_valid_out ? rd_data : 8'h00;
`endif
    end
endmodule
